dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_pkg.sv | 43 ++++
 rtl/dmem_resp_fifo.sv | 58 +++++
 rtl/dmem_resp.sv | 154 +++++++++++++++
 tb/tb_dmem_resp.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared FSM encoding, address map, FIFO sizing and status layout
// for the dmem_resp data-memory responder.
package dmem_resp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] ADDR_RAM_MAX = 8'h3F;
    localparam logic [7:0] ADDR_PORT    = 8'hF0;
    localparam logic [7:0] ADDR_STATUS  = 8'hF1;

    localparam int         FIFO_DEPTH    = 4;
    localparam int         FIFO_PTR_W    = 2;
    localparam logic [2:0] FIFO_FULL_CNT = 3'd4;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_OVF     = 5;

    typedef struct packed {
        logic        is_write;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } req_t;

    function automatic logic [15:0] status_word(
        input logic       empty,
        input logic       full,
        input logic [2:0] count,
        input logic       ovf
    );
        logic [15:0] w;
        w                       = 16'h0000;
        w[STAT_EMPTY]           = empty;
        w[STAT_FULL]            = full;
        w[STAT_CNT_LSB +: 3]    = count;
        w[STAT_OVF]             = ovf;
        return w;
    endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// dmem_resp_fifo: 4-entry output-port FIFO; a push into a full FIFO is dropped
// (flagged on drop) unless a pop happens on the same edge.
module dmem_resp_fifo
    import dmem_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop,
    output logic [15:0] data,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty,
    output logic        drop
);

    logic [15:0]           mem_r [0:FIFO_DEPTH-1];
    logic [FIFO_PTR_W-1:0] wr_ptr_r;
    logic [FIFO_PTR_W-1:0] rd_ptr_r;
    logic [2:0]            count_r;
    logic                  pop_s;
    logic                  push_s;

    assign empty  = (count_r == 3'd0);
    assign full   = (count_r == FIFO_FULL_CNT);
    assign count  = count_r;
    assign pop_s  = pop & ~empty;
    assign push_s = push & (~full | pop_s);
    assign drop   = push & full & ~pop_s;
    assign data   = empty ? 16'h0000 : mem_r[rd_ptr_r];

    // Storage, wrapping pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= {FIFO_PTR_W{1'b0}};
            rd_ptr_r <= {FIFO_PTR_W{1'b0}};
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: CPU data-memory responder (64x16 RAM, output-port FIFO, status word).
// Define DMEM_RESP_WAIT_EN for a 2-cycle WAIT state (1 cycle otherwise).
module dmem_resp
    import dmem_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        we,
    input  logic        outenab,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic [15:0] port_data,
    output logic        port_valid,
    input  logic        port_ready
);

`ifdef DMEM_RESP_WAIT_EN
    localparam logic [1:0] WAIT_LOAD = 2'd1;
`else
    localparam logic [1:0] WAIT_LOAD = 2'd0;
`endif

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [1:0]  wait_cnt_r;
    req_t        req_r;
    logic        ready_r;
    logic [15:0] rdata_r;
    logic        ovf_r;
    logic [15:0] ram_r [0:63];

    logic        req_rd_s;
    logic        req_wr_s;
    logic        accept_s;
    logic        commit_s;
    logic        ram_we_s;
    logic        push_s;
    logic        stat_clr_s;
    logic [15:0] rd_value_s;

    logic [2:0]  fifo_count_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        fifo_drop_s;

    assign req_rd_s   = cs & outenab & ~we;
    assign req_wr_s   = cs & we & ~outenab;
    assign accept_s   = (state_r == ST_IDLE) & (req_rd_s | req_wr_s);

    // Side effects land on the edge that leaves DONE
    assign commit_s   = (state_r == ST_DONE);
    assign ram_we_s   = commit_s & req_r.is_write & (req_r.addr <= ADDR_RAM_MAX);
    assign push_s     = commit_s & req_r.is_write & (req_r.addr == ADDR_PORT);
    assign stat_clr_s = commit_s & ~req_r.is_write & (req_r.addr == ADDR_STATUS);

    assign ready      = ready_r;
    assign rdata      = rdata_r;
    assign port_valid = ~fifo_empty_s;

    dmem_resp_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (req_r.wdata),
        .pop   (port_ready),
        .data  (port_data),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .drop  (fifo_drop_s)
    );

    // Next-state decode for the IDLE/WAIT/DONE handshake
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read mux over RAM, status word and unmapped space
    always_comb begin
        rd_value_s = 16'h0000;
        if (req_r.addr <= ADDR_RAM_MAX) begin
            rd_value_s = ram_r[req_r.addr[5:0]];
        end else if (req_r.addr == ADDR_STATUS) begin
            rd_value_s = status_word(fifo_empty_s, fifo_full_s, fifo_count_s, ovf_r);
        end else begin
            rd_value_s = 16'h0000;
        end
    end

    // FSM, wait counter, latched request and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
            req_r      <= {1'b0, 8'h00, 16'h0000};
            ready_r    <= 1'b0;
            rdata_r    <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                wait_cnt_r <= WAIT_LOAD;
                req_r      <= {req_wr_s, addr, wdata};
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != 2'd0)) begin
                wait_cnt_r <= wait_cnt_r - 2'd1;
            end
            ready_r <= (state_nxt_s == ST_DONE);
            if ((state_nxt_s == ST_DONE) && !req_r.is_write) begin
                rdata_r <= rd_value_s;
            end else begin
                rdata_r <= 16'h0000;
            end
        end
    end

    // Sticky overflow; a fresh drop outranks the clear-on-status-read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (fifo_drop_s) begin
            ovf_r <= 1'b1;
        end else if (stat_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

    // RAM array keeps its contents across reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[req_r.addr[5:0]] <= req_r.wdata;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: table vectors, hand sequences and random accesses for dmem_resp,
// checked against a queue/array model of the memory map.
module tb_dmem_resp;

`ifdef DMEM_RESP_WAIT_EN
    localparam int WAIT_CYC = 2;
`else
    localparam int WAIT_CYC = 1;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        cs         = 1'b0;
    logic        we         = 1'b0;
    logic        outenab    = 1'b0;
    logic        port_ready = 1'b0;
    logic [7:0]  addr       = 8'h00;
    logic [15:0] wdata      = 16'h0000;
    logic [15:0] rdata;
    logic [15:0] port_data;
    logic        ready;
    logic        port_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q[$];
    logic [15:0] ram_m [64];
    bit          ovf_m = 1'b0;

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] e;
    } vec_t;
    vec_t tbl [10];

    dmem_resp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .we         (we),
        .outenab    (outenab),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [2:0] c;
        c = 3'(q.size());
        return {10'b0, ovf_m, c, (c == 3'd4), (c == 3'd0)};
    endfunction

    function automatic logic [15:0] m_read(input logic [7:0] a);
        if (a <= 8'h3F) return ram_m[a[5:0]];
        else if (a == 8'hF1) return m_status();
        else return 16'h0000;
    endfunction

    // One clock edge: check port head, then apply pop / committed write to the model
    task automatic edge_tick(input bit wc, input logic [7:0] a, input logic [15:0] d, input bit sclr);
        bit          pop_m;
        logic [15:0] head;
        head = 16'h0000;
        if (q.size() != 0) head = q[0];
        chk("port", {15'b0, port_valid, port_data}, {15'b0, (q.size() != 0), head});
        pop_m = rst_n && port_ready && (q.size() != 0);
        @(posedge clk);
        if (pop_m) q.delete(0);
        if (wc) begin
            if (a <= 8'h3F) ram_m[a[5:0]] = d;
            else if (a == 8'hF0) begin
                if (q.size() < 4) q.push_back(d);
                else ovf_m = 1'b1;
            end
        end
        if (sclr) ovf_m = 1'b0;
        #1;
    endtask

    task automatic access(input bit w, input logic [7:0] a, input logic [15:0] d,
                          input bit pr_commit, output logic [15:0] got);
        logic [15:0] exp_rd;
        exp_rd = 16'h0000;
        cs = 1'b1; we = w; outenab = ~w; addr = a; wdata = d;
        edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
        for (int k = 0; k < WAIT_CYC; k++) begin
            cs = 1'($urandom); we = 1'($urandom); outenab = 1'($urandom);
            addr = 8'($urandom); wdata = 16'($urandom);
            chk("wait_ready", {31'b0, ready}, 32'd0);
            chk("wait_rdata", {16'b0, rdata}, 32'd0);
            exp_rd = w ? 16'h0000 : m_read(a);
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
        end
        chk("done_ready", {31'b0, ready}, 32'd1);
        chk("done_rdata", {16'b0, rdata}, {16'b0, exp_rd});
        got = rdata;
        if (pr_commit) port_ready = 1'b1;
        edge_tick(w, a, d, (!w && a == 8'hF1));
        if (pr_commit) port_ready = 1'b0;
        cs = 1'b0; we = 1'b0; outenab = 1'b0;
        chk("post_ready", {31'b0, ready}, 32'd0);
        chk("post_rdata", {16'b0, rdata}, 32'd0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] prior;
        logic [7:0]  ra;
        int          sel;

        tbl[0] = '{1'b1, 8'h05, 16'h1234, 16'h0000};
        tbl[1] = '{1'b0, 8'h05, 16'h0000, 16'h1234};
        tbl[2] = '{1'b1, 8'h3F, 16'hBEEF, 16'h0000};
        tbl[3] = '{1'b0, 8'h3F, 16'h0000, 16'hBEEF};
        tbl[4] = '{1'b1, 8'h80, 16'h5555, 16'h0000};
        tbl[5] = '{1'b0, 8'h80, 16'h0000, 16'h0000};
        tbl[6] = '{1'b0, 8'hF0, 16'h0000, 16'h0000};
        tbl[7] = '{1'b0, 8'hF1, 16'h0000, 16'h0001};
        tbl[8] = '{1'b1, 8'h40, 16'h7777, 16'h0000};
        tbl[9] = '{1'b0, 8'h40, 16'h0000, 16'h0000};

        #2 rst_n = 1'b0;
        repeat (3) edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", {16'b0, rdata}, 32'd0);
        chk("rst_port", {15'b0, port_valid, port_data}, 32'd0);
        rst_n = 1'b1;
        edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);

        for (int i = 0; i < 64; i++) access(1'b1, 8'(i), 16'($urandom), 1'b0, got);

        for (int i = 0; i < 10; i++) begin
            access(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, got);
            if (!tbl[i].w) chk($sformatf("tbl%0d", i), {16'b0, got}, {16'b0, tbl[i].e});
        end

        // cs with both strobes, then neither: never accepted
        cs = 1'b1; we = 1'b1; outenab = 1'b1; addr = 8'h05; wdata = 16'hDEAD;
        repeat (WAIT_CYC + 3) begin
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
            chk("both_noready", {31'b0, ready}, 32'd0);
        end
        we = 1'b0; outenab = 1'b0;
        repeat (2) begin
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
            chk("none_noready", {31'b0, ready}, 32'd0);
        end
        cs = 1'b0;
        access(1'b0, 8'h05, 16'h0000, 1'b0, got);
        chk("both_ram", {16'b0, got}, 32'h1234);

        // Overfill with a stalled consumer; status = ovf | count<<2 | full
        port_ready = 1'b0;
        for (int i = 0; i < 5; i++) access(1'b1, 8'hF0, 16'hA001 + 16'(i), 1'b0, got);
        access(1'b0, 8'hF1, 16'h0000, 1'b0, got);
        chk("stat_ovf", {16'b0, got}, {16'b0, 10'b0, 1'b1, 3'd4, 1'b1, 1'b0});
        access(1'b0, 8'hF1, 16'h0000, 1'b0, got);
        chk("stat_clr", {16'b0, got}, {16'b0, 10'b0, 1'b0, 3'd4, 1'b1, 1'b0});
        port_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_a", {15'b0, port_valid, port_data}, {15'b0, 1'b1, 16'hA001 + 16'(i)});
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
        end
        chk("drain_a_empty", {31'b0, port_valid}, 32'd0);
        port_ready = 1'b0;

        // Push into a full FIFO while the head is popped on the same edge
        for (int i = 0; i < 4; i++) access(1'b1, 8'hF0, 16'hB000 + 16'(i), 1'b0, got);
        access(1'b1, 8'hF0, 16'hB004, 1'b1, got);
        access(1'b0, 8'hF1, 16'h0000, 1'b0, got);
        chk("stat_pushpop", {16'b0, got}, {16'b0, 10'b0, 1'b0, 3'd4, 1'b1, 1'b0});
        port_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("drain_b", {15'b0, port_valid, port_data}, {15'b0, 1'b1, 16'hB000 + 16'(i)});
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
        end
        chk("drain_b_empty", {31'b0, port_valid}, 32'd0);
        port_ready = 1'b0;

        // Reset during WAIT of a write aborts it
        prior = ram_m[16];
        cs = 1'b1; we = 1'b1; outenab = 1'b0; addr = 8'h10; wdata = ~prior;
        edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
        cs = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        q.delete(); ovf_m = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'd0);
        repeat (WAIT_CYC + 2) begin
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
            chk("abort_hold", {31'b0, ready}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            edge_tick(1'b0, 8'h00, 16'h0000, 1'b0);
            chk("abort_after", {31'b0, ready}, 32'd0);
        end
        access(1'b0, 8'h10, 16'h0000, 1'b0, got);
        chk("abort_ram", {16'b0, got}, {16'b0, prior});

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 7);
            if (sel < 4) ra = 8'($urandom_range(0, 63));
            else if (sel < 6) ra = 8'hF0;
            else if (sel == 6) ra = 8'hF1;
            else ra = 8'($urandom_range(64, 255));
            port_ready = ($urandom_range(0, 3) == 0);
            access(1'($urandom), ra, 16'($urandom), 1'b0, got);
        end
        port_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
